// File: rtl/sfx_pkg.sv
// Shared types and effect table for the SFX sample sequencer.
// Effect 1 is configured with zero length, so its trigger is inert.
package sfx_pkg;

    localparam int SFX_WIDTH  = 16;
    localparam int SFX_ADDR_W = 14;
    localparam int NUM_SFX    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DRAIN   = 3'd4
    } sfx_state_t;

    typedef logic [1:0] sfx_idx_t;

    // 0=shot, 1=invader killed, 2=player explosion, 3=invader step
    localparam logic [SFX_ADDR_W-1:0] SFX_START [NUM_SFX] = '{14'h0000, 14'h0080, 14'h0100, 14'h0200};
    localparam logic [SFX_ADDR_W-1:0] SFX_LEN   [NUM_SFX] = '{14'd4,    14'd0,    14'd3,    14'd6};

endpackage

// File: rtl/sfx_priority_arbiter.sv
// Combinational lowest-index-wins encoder over the trigger bits.
module sfx_priority_arbiter
    import sfx_pkg::*;
#(
    parameter int N = NUM_SFX
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output sfx_idx_t     idx_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid_o = |req_i;
        idx_o   = 2'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? sfx_idx_t'(i) : idx_o;
        end
    end

endmodule

// File: rtl/sfx_sample_sequencer.sv
// Fetches PCM samples for the active effect and presents them to the I2S transmitter.
// Optional SFX_VOLUME_EN adds a 3-bit arithmetic-shift volume input.
module sfx_sample_sequencer
    import sfx_pkg::*;
#(
    parameter int WIDTH  = SFX_WIDTH,
    parameter int ADDR_W = SFX_ADDR_W
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 onOff,
    input  logic [NUM_SFX-1:0]   trigger,
    input  logic                 Ready,
`ifdef SFX_VOLUME_EN
    input  logic [2:0]           volume,
`endif
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [2*WIDTH-1:0]   Tx,
    output logic                 busy,
    output logic [1:0]           sfx_id
);

    sfx_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]    next_sample_q, next_sample_d;
    logic [2*WIDTH-1:0]  tx_q, tx_d;
    logic                busy_q, busy_d;
    sfx_idx_t            sfx_id_q, sfx_id_d;

    logic                arb_valid_s;
    sfx_idx_t            arb_idx_s;
    logic                start_ok_s;
    logic                preempt_s;
    logic [WIDTH-1:0]    scaled_s;

    sfx_priority_arbiter #(.N(NUM_SFX)) u_arb (
        .req_i   (trigger),
        .valid_o (arb_valid_s),
        .idx_o   (arb_idx_s)
    );

    // Zero-length effects never start; lower index than the current effect preempts.
    always_comb begin
        start_ok_s = arb_valid_s && (SFX_LEN[arb_idx_s] != {SFX_ADDR_W{1'b0}});
        preempt_s  = start_ok_s && (state_q != IDLE) && (arb_idx_s < sfx_id_q);
    end

    // Volume scaling is a sign-preserving shift of the captured sample.
    always_comb begin
`ifdef SFX_VOLUME_EN
        scaled_s = WIDTH'($signed(next_sample_q) >>> volume);
`else
        scaled_s = next_sample_q;
`endif
    end

    // Next-state logic; the Ready update is applied before any preempting restart.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        remaining_d   = remaining_q;
        next_sample_d = next_sample_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        sfx_id_d      = sfx_id_q;

        if (!onOff) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = {(2*WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d = {(2*WIDTH){1'b0}};
                    if (start_ok_s) begin
                        sfx_id_d    = arb_idx_s;
                        rom_addr_d  = ADDR_W'(SFX_START[arb_idx_s]);
                        remaining_d = ADDR_W'(SFX_LEN[arb_idx_s]);
                        busy_d      = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    next_sample_d = rom_data;
                    state_d       = HOLD;
                end
                HOLD: begin
                    if (Ready) begin
                        tx_d        = {scaled_s, scaled_s};
                        remaining_d = remaining_q - ADDR_W'(1);
                        if (remaining_q == ADDR_W'(1)) begin
                            state_d = DRAIN;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                            state_d    = FETCH;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
                DRAIN: begin
                    if (Ready) begin
                        tx_d    = {(2*WIDTH){1'b0}};
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tx_d    = {(2*WIDTH){1'b0}};
                end
            endcase

            if (preempt_s) begin
                sfx_id_d    = arb_idx_s;
                rom_addr_d  = ADDR_W'(SFX_START[arb_idx_s]);
                remaining_d = ADDR_W'(SFX_LEN[arb_idx_s]);
                busy_d      = 1'b1;
                state_d     = FETCH;
            end else begin
                sfx_id_d = sfx_id_d;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= IDLE;
            rom_addr_q    <= {ADDR_W{1'b0}};
            remaining_q   <= {ADDR_W{1'b0}};
            next_sample_q <= {WIDTH{1'b0}};
            tx_q          <= {(2*WIDTH){1'b0}};
            busy_q        <= 1'b0;
            sfx_id_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            remaining_q   <= remaining_d;
            next_sample_q <= next_sample_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            sfx_id_q      <= sfx_id_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign Tx       = tx_q;
    assign busy     = busy_q;
    assign sfx_id   = sfx_id_q;

endmodule

// File: tb/tb_sfx_sample_sequencer.sv
// Scoreboard bench for sfx_sample_sequencer: expected Tx words are queued at trigger time.
module tb_sfx_sample_sequencer;

    logic        Clock;
    logic        nReset;
    logic        onOff;
    logic [3:0]  trigger;
    logic        Ready;
    logic [2:0]  volume;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [31:0] Tx;
    logic        busy;
    logic [1:0]  sfx_id;

    logic        rom_force_en;
    logic [15:0] rom_force;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    sfx_sample_sequencer dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .onOff    (onOff),
        .trigger  (trigger),
        .Ready    (Ready),
`ifdef SFX_VOLUME_EN
        .volume   (volume),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .Tx       (Tx),
        .busy     (busy),
        .sfx_id   (sfx_id)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] rom_model(input logic [13:0] a);
        if (rom_force_en) return rom_force;
        case (a)
            14'h100: return 16'h1111;
            14'h101: return 16'h2222;
            14'h102: return 16'h3333;
            default: return {2'b00, a} ^ 16'h5A00;
        endcase
    endfunction

    always @(posedge Clock) rom_data <= rom_model(rom_addr);

    task automatic pulse_trigger(input logic [3:0] t);
        @(negedge Clock);
        trigger = t;
        @(negedge Clock);
        trigger = 4'b0000;
    endtask

    task automatic frame();
        repeat (4) @(negedge Clock);
        Ready = 1'b1;
        @(negedge Clock);
        Ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (Tx !== 32'h0 || busy !== 1'b0 || rom_addr !== 14'h0 || sfx_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: Tx=%h busy=%b rom_addr=%h sfx_id=%0d, want all zero", Tx, busy, rom_addr, sfx_id);
        end
        @(negedge Clock);
        nReset = 1'b1;
        pulse_trigger(4'b0100);
        frame();
        repeat (3) @(negedge Clock);
        #2 nReset = 1'b0;
        #1;
        tests_run++;
        if (Tx !== 32'h0 || busy !== 1'b0 || rom_addr !== 14'h0) begin
            tests_failed++;
            $display("FAIL async_reset_mid_hold: Tx=%h busy=%b rom_addr=%h, want 0/0/0", Tx, busy, rom_addr);
        end
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame();
            tests_run++;
            if (Tx !== 32'h0) begin
                tests_failed++;
                $display("FAIL ready_after_reset[%0d]: Tx=%h want 00000000", i, Tx);
            end
        end
    endtask

    task automatic test_basic_playback();
        exp_q.delete();
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        exp_q.push_back(32'h00000000);
        pulse_trigger(4'b0100);
        tests_run++;
        if (rom_addr !== 14'h100 || busy !== 1'b1 || sfx_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL start_effect2: rom_addr=%h busy=%b sfx_id=%0d, want 100/1/2", rom_addr, busy, sfx_id);
        end
        for (int i = 0; i < 4; i++) begin
            frame();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (Tx !== exp_v) begin
                tests_failed++;
                $display("FAIL basic_frame[%0d]: Tx=%h want %h", i, Tx, exp_v);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_end: busy=%b want 0", busy);
        end
    endtask

    task automatic test_preempt();
        logic [15:0] s;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            s = rom_model(14'h200 + 14'(k));
            exp_q.push_back({s, s});
        end
        pulse_trigger(4'b1000);
        for (int i = 0; i < 2; i++) begin
            frame();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (Tx !== exp_v) begin
                tests_failed++;
                $display("FAIL effect3_frame[%0d]: Tx=%h want %h", i, Tx, exp_v);
            end
        end
        pulse_trigger(4'b0001);
        tests_run++;
        if (rom_addr !== 14'h000 || sfx_id !== 2'd0 || Tx !== exp_v) begin
            tests_failed++;
            $display("FAIL preempt_restart: rom_addr=%h sfx_id=%0d Tx=%h, want 000/0/%h", rom_addr, sfx_id, Tx, exp_v);
        end
        pulse_trigger(4'b1000);
        tests_run++;
        if (sfx_id !== 2'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL higher_index_ignored: sfx_id=%0d busy=%b, want 0/1", sfx_id, busy);
        end
        for (int k = 0; k < 4; k++) begin
            s = rom_model(14'(k));
            exp_q.push_back({s, s});
        end
        exp_q.push_back(32'h0);
        for (int i = 0; i < 5; i++) begin
            frame();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (Tx !== exp_v) begin
                tests_failed++;
                $display("FAIL effect0_frame[%0d]: Tx=%h want %h", i, Tx, exp_v);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL effect0_busy_end: busy=%b want 0", busy);
        end
    endtask

    task automatic test_multi_trigger();
        pulse_trigger(4'b0011);
        tests_run++;
        if (sfx_id !== 2'd0 || busy !== 1'b1 || rom_addr !== 14'h000) begin
            tests_failed++;
            $display("FAIL multi_trigger: sfx_id=%0d busy=%b rom_addr=%h, want 0/1/000", sfx_id, busy, rom_addr);
        end
    endtask

    task automatic test_onoff();
        logic [15:0] s;
        exp_q.delete();
        s = rom_model(14'h000);
        exp_q.push_back({s, s});
        frame();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (Tx !== exp_v) begin
            tests_failed++;
            $display("FAIL onoff_first_frame: Tx=%h want %h", Tx, exp_v);
        end
        @(negedge Clock);
        onOff = 1'b0;
        @(negedge Clock);
        tests_run++;
        if (Tx !== 32'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL onoff_mute: Tx=%h busy=%b, want 0/0", Tx, busy);
        end
        pulse_trigger(4'b0100);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL trigger_while_off: busy=%b want 0", busy);
        end
        onOff = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame();
            tests_run++;
            if (Tx !== 32'h0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL onoff_no_resume[%0d]: Tx=%h busy=%b, want 0/0", i, Tx, busy);
            end
        end
    endtask

    task automatic test_zero_len();
        pulse_trigger(4'b0010);
        repeat (2) @(negedge Clock);
        tests_run++;
        if (busy !== 1'b0 || Tx !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_len_ignored: busy=%b Tx=%h, want 0/0", busy, Tx);
        end
        frame();
        tests_run++;
        if (Tx !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_len_frame: Tx=%h want 00000000", Tx);
        end
    endtask

`ifdef SFX_VOLUME_EN
    task automatic test_volume();
        exp_q.delete();
        exp_q.push_back(32'hE000E000);
        exp_q.push_back(32'h10001000);
        volume       = 3'd2;
        rom_force_en = 1'b1;
        rom_force    = 16'h8000;
        pulse_trigger(4'b0100);
        frame();
        rom_force = 16'h4000;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (Tx !== exp_v) begin
            tests_failed++;
            $display("FAIL volume_negative: Tx=%h want %h", Tx, exp_v);
        end
        frame();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (Tx !== exp_v) begin
            tests_failed++;
            $display("FAIL volume_positive: Tx=%h want %h", Tx, exp_v);
        end
        @(negedge Clock);
        onOff = 1'b0;
        @(negedge Clock);
        onOff        = 1'b1;
        rom_force_en = 1'b0;
        volume       = 3'd0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nReset       = 1'b0;
        onOff        = 1'b1;
        trigger      = 4'b0000;
        Ready        = 1'b0;
        volume       = 3'd0;
        rom_force_en = 1'b0;
        rom_force    = 16'h0000;
        repeat (2) @(negedge Clock);
        test_reset();
        test_basic_playback();
        test_preempt();
        test_multi_trigger();
        test_onoff();
        test_zero_len();
`ifdef SFX_VOLUME_EN
        test_volume();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
